// File: rtl/neuron_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_pkg
// Description : Q8.8 constants and FSM state encoding shared by neuron_mac.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_mac_pkg;

    localparam int          Q_FRAC = 8;
    localparam logic [15:0] Q_ONE  = 16'h0100;
    localparam logic [15:0] Q_MAX  = 16'h7FFF;
    localparam logic [15:0] Q_MIN  = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_FIN  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage : neuron_mac_pkg
`default_nettype wire

// File: rtl/neuron_mac_mult.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_mult
// Description : Q8.8 signed multiplier; keeps the Q8.8 window of the Q16.16
//               product (truncated toward -inf, upper bits wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_mult
    import neuron_mac_pkg::*;
(
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [15:0] p
);

    logic signed [31:0] full_prod;
    logic               unused_bits;

    assign full_prod   = a * b;
    assign p           = full_prod[Q_FRAC+15:Q_FRAC];
    assign unused_bits = ^{full_prod[31:Q_FRAC+16], full_prod[Q_FRAC-1:0]};

endmodule : neuron_mac_mult
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Sequential Q8.8 multiply-accumulate for one neuron: N_IN
//               streamed pairs, bias add, Q8.8 saturation, optional ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int ACC_W = 24,
    parameter int RELU  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_y,
    output logic        busy
);

    localparam int                CNT_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_IN - 1);
    localparam logic signed [ACC_W:0] S_MAX = {{(ACC_W+1-16){1'b0}}, Q_MAX};
    localparam logic signed [ACC_W:0] S_MIN = {{(ACC_W+1-16){1'b1}}, Q_MIN};

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [15:0]              bias_q, bias_d;
    logic [15:0]              out_y_q, out_y_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;

    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W:0]    sum_s;
    logic [15:0]              sat;
    logic [15:0]              result;

    neuron_mac_mult u_mult (
        .a (in_x),
        .b (in_w),
        .p (prod)
    );

    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};

    // One extra bit so the bias add can never wrap before the clamp.
    assign sum_s = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-16){bias_q[15]}}, bias_q};

    always_comb begin
        if (sum_s > S_MAX) begin
            sat = Q_MAX;
        end else if (sum_s < S_MIN) begin
            sat = Q_MIN;
        end else begin
            sat = sum_s[15:0];
        end
        result = ((RELU != 0) && sat[15]) ? 16'h0000 : sat;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bias_d      = bias_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid && in_ready_q) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                out_y_d     = result;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_ACC);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign busy      = busy_q;

endmodule : neuron_mac
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac
// Description : Directed self-checking bench for neuron_mac (ReLU and linear
//               instances side by side, N_IN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bias;
    logic        in_valid;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        out_ready;

    logic        in_ready_r, out_valid_r, busy_r;
    logic [15:0] out_y_r;
    logic        in_ready_l, out_valid_l, busy_l;
    logic [15:0] out_y_l;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_r[$];
    logic [15:0] exp_l[$];
    logic [15:0] vx [4];
    logic [15:0] vw [4];

    always #5 clk = ~clk;

    neuron_mac #(.N_IN(4), .ACC_W(24), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_x(in_x), .in_w(in_w),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_y(out_y_r), .busy(busy_r)
    );

    neuron_mac #(.N_IN(4), .ACC_W(24), .RELU(0)) u_lin (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_x(in_x), .in_w(in_w),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_y(out_y_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Neuron output from plain integer arithmetic on real Q8.8 values.
    function automatic logic [15:0] model(input logic [15:0] b, input logic [15:0] xs [4],
                                          input logic [15:0] ws [4], input bit relu);
        longint      s;
        longint      prod;
        logic [15:0] p16;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            prod = longint'($signed(xs[i])) * longint'($signed(ws[i]));
            prod = prod >>> 8;
            p16  = prod[15:0];
            s   += longint'($signed(p16));
        end
        s += longint'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s[15:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_agree", {15'd0, out_valid_l}, {15'd0, out_valid_r});
            if (out_valid_r) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", out_y_r);
                end else begin
                    chk("model_relu", out_y_r, exp_r[0]);
                    chk("model_lin", out_y_l, exp_l[0]);
                    if (out_ready) begin
                        void'(exp_r.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_pair(input logic [15:0] x, input logic [15:0] w);
        int n;
        n        = 0;
        in_x     = x;
        in_w     = w;
        in_valid = 1'b1;
        while (!in_ready_r && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", {15'd0, in_ready_r}, 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_eval(input string name, input logic [15:0] b, input int gap, input int bp,
                            input logic [15:0] lit_r, input logic [15:0] lit_l);
        exp_r.push_back(model(b, vx, vw, 1'b1));
        exp_l.push_back(model(b, vx, vw, 1'b0));
        start = 1'b1;
        bias  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        bias  = 16'h0000;
        chk({name, "_busy_acc"}, {15'd0, busy_r}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    chk({name, "_gap_in_ready"}, {15'd0, in_ready_r}, 16'd1);
                    @(posedge clk);
                    #1;
                end
            end
            send_pair(vx[i], vw[i]);
        end
        chk({name, "_fin_valid"}, {15'd0, out_valid_r}, 16'd0);
        chk({name, "_fin_in_ready"}, {15'd0, in_ready_r}, 16'd0);
        @(posedge clk);
        #1;
        chk({name, "_lat_valid"}, {15'd0, out_valid_r}, 16'd1);
        chk({name, "_lit_relu"}, out_y_r, lit_r);
        chk({name, "_lit_lin"}, out_y_l, lit_l);
        for (int c = 0; c < bp; c++) begin
            start = (c == 2);
            bias  = 16'h7000;
            chk({name, "_bp_valid"}, {15'd0, out_valid_r}, 16'd1);
            chk({name, "_bp_y"}, out_y_r, lit_r);
            chk({name, "_bp_in_ready"}, {15'd0, in_ready_r}, 16'd0);
            chk({name, "_bp_busy"}, {15'd0, busy_r}, 16'd1);
            @(posedge clk);
            #1;
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b0;
        bias      = 16'h0000;
        chk({name, "_done_valid"}, {15'd0, out_valid_r}, 16'd0);
        chk({name, "_done_busy"}, {15'd0, busy_r}, 16'd0);
        chk({name, "_held_y"}, out_y_r, lit_r);
        @(posedge clk);
        #1;
        chk({name, "_idle_busy"}, {15'd0, busy_r}, 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bias      = 16'h0000;
        in_valid  = 1'b0;
        in_x      = 16'h0000;
        in_w      = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_y", out_y_r, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid_r}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready_r}, 16'd0);
        chk("rst_busy", {15'd0, busy_r}, 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        vx = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        vw = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run_eval("basic", 16'h0000, 0, 0, 16'h0200, 16'h0200);

        vx = '{16'h6400, 16'h6400, 16'h6400, 16'h6400};
        vw = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        run_eval("sat_pos", 16'h0100, 0, 0, 16'h7FFF, 16'h7FFF);

        vx = '{16'h9C00, 16'h9C00, 16'h9C00, 16'h9C00};
        run_eval("sat_neg", 16'h0100, 0, 0, 16'h0000, 16'h8000);

        vx = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        vw = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        run_eval("sign", 16'h0080, 0, 0, 16'h0000, 16'hFC80);

        vw = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run_eval("gaps", 16'h0000, 3, 0, 16'h0200, 16'h0200);

        vx = '{16'h0180, 16'hFF40, 16'h0300, 16'h0020};
        vw = '{16'h0200, 16'h0100, 16'hFFC0, 16'h0A00};
        run_eval("bp", 16'h0010, 0, 5, 16'h02D0, 16'h02D0);

        // Abort after two beats; the held 0x02D0 must be cleared by reset.
        vx = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        vw = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        start = 1'b1;
        bias  = 16'h0100;
        @(posedge clk);
        #1;
        start = 1'b0;
        bias  = 16'h0000;
        send_pair(16'h6400, 16'h0100);
        send_pair(16'h6400, 16'h0100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_y", out_y_r, 16'h0000);
        chk("abort_out_valid", {15'd0, out_valid_r}, 16'd0);
        chk("abort_in_ready", {15'd0, in_ready_r}, 16'd0);
        chk("abort_busy", {15'd0, busy_r}, 16'd0);
        @(posedge clk);
        #1;
        run_eval("fresh", 16'h0000, 0, 0, 16'h0200, 16'h0200);

        chk("pending_outputs", 16'(exp_r.size()), 16'd0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_neuron_mac
`default_nettype wire
